// File: rtl/multibyte_add_sequencer.sv
// multibyte_add_sequencer: NBYTES-wide add done byte-serially (LSB first) on one shared 8-bit adder
//   Clk, Reset           : clock, synchronous active-high reset
//   Start/Ready          : request handshake, OpA/OpB/CinIn captured on accept
//   Busy/Done            : in-progress flag, one-cycle completion pulse
//   Result/CoutOut       : registered sum and top-byte carry
//   AddA/AddB/AddCin/AddEnable -> shared adder, AddSum/AddCout <- shared adder
module multibyte_add_sequencer #(
  parameter int NBYTES    = 4,
  parameter bit EN_ACTIVE = 1'b1
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  Start,
  input  logic [8*NBYTES-1:0]   OpA,
  input  logic [8*NBYTES-1:0]   OpB,
  input  logic                  CinIn,
  output logic                  Ready,
  output logic                  Busy,
  output logic                  Done,
  output logic [8*NBYTES-1:0]   Result,
  output logic                  CoutOut,
  output logic [7:0]            AddA,
  output logic [7:0]            AddB,
  output logic                  AddCin,
  output logic                  AddEnable,
  input  logic [7:0]            AddSum,
  input  logic                  AddCout
);
  localparam int IW = NBYTES > 1 ? $clog2(NBYTES) : 1;
  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;
  state_t state, next;
  logic [IW-1:0] idx;
  logic [NBYTES-1:0][7:0] op_a, op_b, res;
  logic carry, last;
  assign last = idx == IW'(NBYTES - 1);
  assign Result = res;
  always_ff @(posedge Clk) state <= Reset ? IDLE : next;
  always_comb begin
    next = state;
    Ready = 1'b0;
    Busy = 1'b0;
    Done = 1'b0;
    AddA = '0;
    AddB = '0;
    AddCin = 1'b0;
    AddEnable = ~EN_ACTIVE;
    case (state)
      IDLE: begin
        Ready = 1'b1;
        next = Start ? ADD : IDLE;
      end
      ADD: begin
        Busy = 1'b1;
        AddA = op_a[idx];
        AddB = op_b[idx];
        AddCin = carry;
        AddEnable = EN_ACTIVE;
        next = last ? DONE : ADD;
      end
      DONE: begin
        Busy = 1'b1;
        Done = 1'b1;
        next = IDLE;
      end
      default: next = IDLE;
    endcase
  end
  // carry reg is the only path between bytes, so each byte sees the previous byte's Cout
  always_ff @(posedge Clk) begin
    if (Reset) begin
      op_a <= '0;
      op_b <= '0;
      res <= '0;
      idx <= '0;
      carry <= 1'b0;
      CoutOut <= 1'b0;
    end else if (state == IDLE && Start) begin
      op_a <= OpA;
      op_b <= OpB;
      carry <= CinIn;
      idx <= '0;
      res <= '0;
      CoutOut <= 1'b0;
    end else if (state == ADD) begin
      res[idx] <= AddSum;
      carry <= AddCout;
      idx <= last ? '0 : idx + IW'(1);
      if (last) CoutOut <= AddCout;
    end
  end
endmodule

// eight_bit_adder_with_enable: combinational 8-bit adder, outputs forced to 0 when disabled
module eight_bit_adder_with_enable (
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic       Cin0,
  input  logic       Enable,
  output logic [7:0] Sum,
  output logic       Cout8
);
  assign {Cout8, Sum} = Enable ? {1'b0, A} + {1'b0, B} + {8'd0, Cin0} : 9'd0;
endmodule

// File: tb/tb_multibyte_add_sequencer.sv
// tb_multibyte_add_sequencer: directed checks of the byte-serial add sequencer with a real 8-bit adder
module tb_multibyte_add_sequencer;
  logic Clk, Reset, Start, CinIn;
  logic [31:0] OpA, OpB, Result;
  logic Ready, Busy, Done, CoutOut, AddCin, AddEnable, AddCout;
  logic [7:0] AddA, AddB, AddSum;
  int tests = 0;
  int fails = 0;
  int n;
  int dones;
  logic cins [20];

  multibyte_add_sequencer #(.NBYTES(4), .EN_ACTIVE(1'b1)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .OpA(OpA), .OpB(OpB), .CinIn(CinIn),
    .Ready(Ready), .Busy(Busy), .Done(Done), .Result(Result), .CoutOut(CoutOut),
    .AddA(AddA), .AddB(AddB), .AddCin(AddCin), .AddEnable(AddEnable),
    .AddSum(AddSum), .AddCout(AddCout)
  );

  eight_bit_adder_with_enable u_add (
    .A(AddA), .B(AddB), .Cin0(AddCin), .Enable(AddEnable), .Sum(AddSum), .Cout8(AddCout)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  // ticks until Done (bounded); n counts cycles from the accept cycle, cins[i] holds AddCin of byte i
  task automatic wait_done;
    n = 1;
    cins[0] = AddCin;
    while (!Done && n < 20) begin
      tick;
      n++;
      if (!Done) cins[n-1] = AddCin;
    end
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic c, input logic [31:0] er, input logic ec);
    OpA = a;
    OpB = b;
    CinIn = c;
    Start = 1'b1;
    tick;
    Start = 1'b0;
    OpA = ~a;
    OpB = ~b;
    chk({tag, "_ready_low"}, Ready, 0);
    chk({tag, "_busy"}, Busy, 1);
    chk({tag, "_result_cleared"}, Result, 0);
    chk({tag, "_adda0"}, AddA, a[7:0]);
    chk({tag, "_addb0"}, AddB, b[7:0]);
    chk({tag, "_addcin0"}, AddCin, c);
    chk({tag, "_enable"}, AddEnable, 1);
    wait_done;
    chk({tag, "_latency"}, n, 5);
    chk({tag, "_result"}, Result, er);
    chk({tag, "_cout"}, CoutOut, ec);
    chk({tag, "_enable_done"}, AddEnable, 0);
    tick;
    chk({tag, "_done_pulse"}, Done, 0);
    chk({tag, "_ready_back"}, Ready, 1);
    chk({tag, "_result_hold"}, Result, er);
  endtask

  initial begin
    Reset = 1'b1;
    Start = 1'b0;
    OpA = '0;
    OpB = '0;
    CinIn = 1'b0;
    tick;
    tick;
    Reset = 1'b0;
    chk("rst_ready", Ready, 1);
    chk("rst_busy", Busy, 0);
    chk("rst_done", Done, 0);
    chk("rst_result", Result, 0);
    chk("rst_cout", CoutOut, 0);
    chk("rst_enable", AddEnable, 0);
    chk("rst_adda", AddA, 0);
    chk("rst_addcin", AddCin, 0);
    run_op("t1", 32'h0000_0000, 32'h0000_0001, 1'b0, 32'h0000_0001, 1'b0);
    tick;
    tick;
    chk("t1_idle_hold", Result, 32'h0000_0001);
    run_op("t2", 32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0);
    chk("t2_cin1", cins[1], 1);
    chk("t2_cin2", cins[2], 0);
    run_op("t3", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1);
    chk("t3_cin1", cins[1], 1);
    chk("t3_cin2", cins[2], 1);
    chk("t3_cin3", cins[3], 1);
    run_op("t4a", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1);
    run_op("t4b", 32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0);
    OpA = 32'h0102_0304;
    OpB = 32'h1020_3040;
    CinIn = 1'b0;
    Start = 1'b1;
    tick;
    OpA = 32'hAAAA_AAAA;
    OpB = 32'h5555_5555;
    CinIn = 1'b1;
    wait_done;
    chk("t5_latency", n, 5);
    chk("t5_result_first", Result, 32'h1122_3344);
    chk("t5_cout_first", CoutOut, 0);
    tick;
    chk("t5_single_done", Done, 0);
    chk("t5_ready_idle", Ready, 1);
    tick;
    chk("t5_held_accept", Busy, 1);
    Start = 1'b0;
    wait_done;
    chk("t5_latency2", n, 5);
    chk("t5_result_second", Result, 32'h0000_0000);
    chk("t5_cout_second", CoutOut, 1);
    tick;
    OpA = 32'hFFFF_FFFF;
    OpB = 32'h0000_0001;
    CinIn = 1'b0;
    Start = 1'b1;
    tick;
    Start = 1'b0;
    tick;
    tick;
    chk("t6_byte2_cin", AddCin, 1);
    chk("t6_byte2_adda", AddA, 8'hFF);
    Reset = 1'b1;
    tick;
    Reset = 1'b0;
    chk("t6_ready", Ready, 1);
    chk("t6_busy", Busy, 0);
    chk("t6_result", Result, 0);
    chk("t6_cout", CoutOut, 0);
    chk("t6_enable", AddEnable, 0);
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      if (Done) dones++;
      tick;
    end
    chk("t6_no_done", dones, 0);
    run_op("t6_after", 32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/multibyte_add_sequencer.md
Name: multibyte_add_sequencer

Overview:
Sequencer that performs an NBYTES-wide addition by time-multiplexing one external eight_bit_adder_with_enable, one byte per clock, LSB byte first. It captures the operands on a Start/Ready handshake and drives the adder's A, B, Cin and Enable. It registers each byte sum and chains the byte carry-out into the next byte's carry-in. It returns the full result with a one-cycle Done pulse. It sits between a requesting controller and the shared 8-bit adder datapath.

Parameters:
NBYTES, 4, number of 8-bit bytes per operand (legal range 1..16).
EN_ACTIVE, 1, level driven on AddEnable while a byte add is in progress; the inverse level is driven otherwise.

Ports:
Clk  input  1  system clock, rising edge.
Reset  input  1  synchronous, active-high reset.
Start  input  1  request strobe; accepted only when Ready=1.
OpA  input  8*NBYTES  operand A, sampled on accept.
OpB  input  8*NBYTES  operand B, sampled on accept.
CinIn  input  1  carry-in for byte 0, sampled on accept.
Ready  output  1  high in IDLE only.
Busy  output  1  high in ADD and DONE.
Done  output  1  one-cycle pulse; Result and CoutOut are valid from this cycle onward.
Result  output  8*NBYTES  registered sum.
CoutOut  output  1  registered carry-out of the top byte.
AddA  output  8  to adder A.
AddB  output  8  to adder B.
AddCin  output  1  to adder Cin0.
AddEnable  output  1  to adder Enable.
AddSum  input  8  from adder Sum (combinational).
AddCout  input  1  from adder Cout8.

Behaviour:
- Reset (sync): state=IDLE, ByteIdx=0, carry reg=0, Result=0, CoutOut=0, Done=0, Busy=0, Ready=1, AddA=AddB=0, AddCin=0, AddEnable=~EN_ACTIVE.
- States: IDLE, ADD, DONE.
- IDLE:
  - Ready=1. On Start=1, latch OpA, OpB into operand regs and CinIn into the carry reg, clear ByteIdx, go to ADD.
  - Result and CoutOut keep their previous values until the accept edge, then clear to 0.
- ADD, one cycle per byte i=ByteIdx:
  - AddA=OpA_reg[8i+7:8i], AddB=OpB_reg[8i+7:8i], AddCin=carry reg, AddEnable=EN_ACTIVE.
  - At the clock edge: Result[8i+7:8i]<=AddSum; carry reg<=AddCout; ByteIdx++.
  - When i=NBYTES-1, CoutOut<=AddCout and go to DONE.
- DONE: Done=1 for exactly one cycle, AddEnable=~EN_ACTIVE, next state IDLE.
- Latency: accept edge to Done high is NBYTES+1 cycles. Back-to-back throughput is one op per NBYTES+2 cycles, because Ready returns in the cycle after Done.
- Adder port values outside ADD: AddA, AddB and AddCin are 0 and AddEnable is inactive. AddSum and AddCout are ignored outside ADD.
- Start while Busy=1: ignored, not queued. Operand inputs may change freely after accept.
- Reset mid-operation: aborts immediately to the reset state. Done does not pulse and partial Result is discarded (0).
- Arithmetic: unsigned modulo 2^(8*NBYTES). CoutOut is the true carry out of the MSB byte. The carry chains only through the carry reg and never skips a byte.
- NBYTES=1: ADD lasts one cycle; behaviour otherwise identical.

Test Plan:
Bench uses NBYTES=4 and EN_ACTIVE=1, with a real eight_bit_adder_with_enable instance wired to the Add* ports.
1. OpA=0x00000000, OpB=0x00000001, CinIn=0, Start for 1 cycle -> Ready drops next cycle, Done pulses 5 cycles after accept, Result=0x00000001, CoutOut=0.
2. OpA=0x000000FF, OpB=0x00000001, CinIn=0 -> Result=0x00000100, CoutOut=0, which checks the byte-0 carry chaining into byte 1.
3. OpA=0xFFFFFFFF, OpB=0x00000001 -> Result=0x00000000, CoutOut=1. Also check AddCin=1 on bytes 1..3.
4. OpA=0xFFFFFFFF, OpB=0x00000000, CinIn=1 -> Result=0x00000000, CoutOut=1. Then re-Start with 0x12345678 + 0x11111111 -> Result=0x23456789, CoutOut=0.
5. Start=1 held during ADD with different operands -> the second request is ignored, exactly one Done pulse, Result equals the first request's sum. The held Start is then accepted in the IDLE cycle.
6. Reset asserted for 1 cycle during byte 2 of 0xFFFFFFFF+1 -> next cycle Ready=1, Busy=0, Result=0, CoutOut=0, no Done pulse. A subsequent op completes correctly.
